// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the WB stage and a queued
// multi-cycle result stream, with a starvation timer that forces one MC write.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  output logic        stall_wb,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FORCE} state_t;

  state_t        state_reg, state_next;
  logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [4:0]    mem_rd   [DEPTH];
  logic [31:0]   mem_data [DEPTH];

  logic [AW:0]   count, count_next;
  logic          fifo_empty, fifo_full;
  logic          push, pop;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic [DEPTH-1:0] entry_valid, hit1, hit2;

  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign mc_ready   = !fifo_full;
  // Writes to x0 are architecturally dead, so they are acknowledged but dropped.
  assign push       = mc_valid && !fifo_full && (mc_rd != 5'd0);
  assign head_rd    = mem_rd[rd_ptr_reg[AW-1:0]];
  assign head_data  = mem_data[rd_ptr_reg[AW-1:0]];

  // Slot gi is occupied when its distance from the read pointer is below the fill level.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] offset;
      assign offset          = AW'(gi) - rd_ptr_reg[AW-1:0];
      assign entry_valid[gi] = ({1'b0, offset} < count);
      assign hit1[gi]        = entry_valid[gi] && (mem_rd[gi] == rs1);
      assign hit2[gi]        = entry_valid[gi] && (mem_rd[gi] == rs2);
    end
  endgenerate

  assign pend_hit1 = (|hit1) && (rs1 != 5'd0);
  assign pend_hit2 = (|hit2) && (rs2 != 5'd0);

  always_comb begin
    stall_wb = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    pop      = 1'b0;
    if (state_reg == ST_FORCE) begin
      stall_wb = 1'b1;
      rf_we    = 1'b1;
      rf_waddr = head_rd;
      rf_wdata = head_data;
      pop      = 1'b1;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd;
      rf_wdata = wb_data;
    end else if (!fifo_empty) begin
      rf_we    = 1'b1;
      rf_waddr = head_rd;
      rf_wdata = head_data;
      pop      = 1'b1;
    end
  end

  always_comb begin
    count_next    = count + (AW+1)'(push) - (AW+1)'(pop);
    wait_cnt_next = '0;
    state_next    = (count_next != '0) ? ST_WAIT : ST_IDLE;
    if (state_reg == ST_WAIT && !pop) begin
      if (wait_cnt_reg == CW'(MAX_WAIT - 1)) begin
        state_next = ST_FORCE;
      end else begin
        wait_cnt_next = wait_cnt_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wr_ptr_reg   <= wr_ptr_reg + (AW+1)'(push);
      rd_ptr_reg   <= rd_ptr_reg + (AW+1)'(pop);
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Storage needs no reset: occupancy is defined solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr_reg[AW-1:0]]   <= mc_rd;
      mem_data[wr_ptr_reg[AW-1:0]] <= mc_data;
    end
  end

endmodule
